// File: rtl/cmi_decoder.sv
// CMI receive decoder: recovers chip-pair alignment, decodes pairs back to NRZ,
// flags code violations and tracks lock with a windowed loss detector.
module cmi_decoder #(
    parameter int LOCK_GOOD = 8,
    parameter int WIN_LEN   = 32,
    parameter int LOSS_BAD  = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk_sig,
    input  logic             reset_sig,
    input  logic             chip_en,
    input  logic             serial_in,
    output logic             decode_sig,
    output logic             decode_valid,
    output logic             locked,
    output logic             cv_err,
    output logic [CNT_W-1:0] cv_count
);

    localparam int GOOD_W = $clog2(LOCK_GOOD + 1);
    localparam int WIN_W  = $clog2(WIN_LEN + 1);
    localparam int BAD_W  = $clog2(LOSS_BAD + 1);

    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_GOOD - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_LEN - 1);
    localparam logic [BAD_W-1:0]  BAD_LIMIT = BAD_W'(LOSS_BAD);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCK
    } state_t;

    state_t            state;
    logic              phase;
    logic              slip_pending;
    logic              c0;
    logic              ref_valid;
    logic              last_one_level;
    logic [GOOD_W-1:0] good_cnt;
    logic [WIN_W-1:0]  win_cnt;
    logic [BAD_W-1:0]  bad_cnt;

    logic              pair_done;
    logic              one_pair;
    logic              pair_viol;
    logic              win_roll;
    logic [BAD_W-1:0]  bad_next;

    always_comb begin
        // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
        pair_done = chip_en && phase;
        one_pair  = (c0 == serial_in);
        pair_viol = (c0 && !serial_in)
                 || (one_pair && ref_valid && (serial_in == last_one_level));
        win_roll  = (win_cnt == WIN_LAST);
        // A violation on the rollover pair belongs to the new window.
        bad_next  = (win_roll ? '0 : bad_cnt) + BAD_W'(pair_viol);
    end

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_sig) begin
        if (reset_sig) begin
            state          <= HUNT;
            phase          <= 1'b0;
            slip_pending   <= 1'b0;
            c0             <= 1'b0;
            ref_valid      <= 1'b0;
            last_one_level <= 1'b0;
            good_cnt       <= '0;
            win_cnt        <= '0;
            bad_cnt        <= '0;
            decode_sig     <= 1'b0;
            decode_valid   <= 1'b0;
            locked         <= 1'b0;
            cv_err         <= 1'b0;
            cv_count       <= '0;
        end else begin
            decode_valid <= 1'b0;
            cv_err       <= 1'b0;

            if (chip_en && slip_pending) begin
                // Dropped chip: phase stays 0 so the next chip opens a pair.
                slip_pending <= 1'b0;
            end else if (chip_en && !phase) begin
                c0    <= serial_in;
                phase <= 1'b1;
            end else if (pair_done) begin
                phase <= 1'b0;
                if (one_pair && !pair_viol) begin
                    last_one_level <= serial_in;
                    ref_valid      <= 1'b1;
                end

                case (state)
                    HUNT: begin
                        if (pair_viol) begin
                            slip_pending <= 1'b1;
                            ref_valid    <= 1'b0;
                        end else begin
                            good_cnt <= GOOD_W'(1);
                            state    <= CHECK;
                        end
                    end

                    CHECK: begin
                        if (pair_viol) begin
                            slip_pending <= 1'b1;
                            ref_valid    <= 1'b0;
                            good_cnt     <= '0;
                            state        <= HUNT;
                        end else begin
                            good_cnt <= good_cnt + GOOD_W'(1);
                            if (good_cnt == GOOD_LAST) begin
                                state   <= LOCK;
                                locked  <= 1'b1;
                                win_cnt <= '0;
                                bad_cnt <= '0;
                            end
                        end
                    end

                    LOCK: begin
                        decode_valid <= 1'b1;
                        decode_sig   <= one_pair;
                        cv_err       <= pair_viol;
                        if (pair_viol && (cv_count != CNT_MAX)) begin
                            cv_count <= cv_count + CNT_W'(1);
                        end
                        win_cnt <= win_roll ? '0 : win_cnt + WIN_W'(1);
                        bad_cnt <= bad_next;
                        if (bad_next == BAD_LIMIT) begin
                            state        <= HUNT;
                            locked       <= 1'b0;
                            slip_pending <= 1'b1;
                            ref_valid    <= 1'b0;
                            good_cnt     <= '0;
                        end
                    end

                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule
